dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 138 +++++++++++++
 tb/tb_dmem_responder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: single-port data memory behind a valid/ready request and
// valid/ready response handshake, with a fixed request-to-response latency.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset (memory contents unaffected)
//   req_valid   initiator presents a request
//   req_ready   responder can accept a request (high only while idle)
//   req_addr    byte address; must be word aligned and < 4*DEPTH_WORDS
//   req_rw      1 = write, 0 = read
//   req_wdata   write data
//   resp_valid  response valid; held until resp_ready
//   resp_ready  initiator accepts the response
//   resp_rdata  read data (0 for writes and errors)
//   resp_err    misaligned or out-of-range request
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_rw,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // WAIT exits on the edge where the counter reads 0, so LATENCY-1 edges are
  // spent between accept and commit; LATENCY=1 commits on the accept edge.
  localparam logic [3:0] CNT_LOAD = 4'((LATENCY > 1) ? LATENCY - 2 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic        rw_q;
  logic [31:0] wdata_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic [31:0] rdata_q;
  logic        err_q;

  // Zero at time zero; never touched by reset.
  logic [31:0] mem_q [DEPTH_WORDS] = '{default: '0};

  logic          accept;
  logic          commit;
  logic [31:0]   c_addr;
  logic          c_rw;
  logic [31:0]   c_wdata;
  logic          c_err;
  logic [AW-1:0] c_idx;

  assign accept = req_valid & req_ready_q;

  // Commit happens either on the accept edge (LATENCY=1, live inputs) or on
  // the WAIT exit edge (latched request).
  assign commit = ((state_q == IDLE) & accept & (LATENCY == 1)) |
                  ((state_q == WAIT) & (cnt_q == 4'd0));

  always_comb begin
    c_addr  = addr_q;
    c_rw    = rw_q;
    c_wdata = wdata_q;
    if (state_q == IDLE) begin
      c_addr  = req_addr;
      c_rw    = req_rw;
      c_wdata = req_wdata;
    end
  end

  assign c_err = (c_addr[1:0] != 2'b00) | ((c_addr >> (AW + 2)) != 32'd0);
  assign c_idx = c_addr[AW+1:2];

  always_ff @(posedge clk) begin
    if (!rst && commit && c_rw && !c_err) mem_q[c_idx] <= c_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q      <= req_addr;
            rw_q        <= req_rw;
            wdata_q     <= req_wdata;
            req_ready_q <= 1'b0;
            state_q     <= WAIT;
            cnt_q       <= CNT_LOAD;
          end
        end
        WAIT: begin
          if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'd0;
            err_q        <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
      // Overrides the IDLE/WAIT moves above on the commit edge.
      if (commit) begin
        state_q      <= RESP;
        resp_valid_q <= 1'b1;
        err_q        <= c_err;
        rdata_q      <= (c_rw | c_err) ? 32'd0 : mem_q[c_idx];
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int LAT2  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // LATENCY=2 instance
  logic        r2_valid = 0, r2_ready, r2_rw = 0, p2_valid, p2_ready = 0, p2_err;
  logic [31:0] r2_addr = 0, r2_wdata = 0, p2_rdata;
  // LATENCY=1 instance, resp_ready tied high
  logic        r1_valid = 0, r1_ready, r1_rw = 0, p1_valid, p1_err;
  logic [31:0] r1_addr = 0, r1_wdata = 0, p1_rdata;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT2)) du2 (
    .clk(clk), .rst(rst),
    .req_valid(r2_valid), .req_ready(r2_ready), .req_addr(r2_addr),
    .req_rw(r2_rw), .req_wdata(r2_wdata),
    .resp_valid(p2_valid), .resp_ready(p2_ready),
    .resp_rdata(p2_rdata), .resp_err(p2_err));

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) du1 (
    .clk(clk), .rst(rst),
    .req_valid(r1_valid), .req_ready(r1_ready), .req_addr(r1_addr),
    .req_rw(r1_rw), .req_wdata(r1_wdata),
    .resp_valid(p1_valid), .resp_ready(1'b1),
    .resp_rdata(p1_rdata), .resp_err(p1_err));

  // Reference: word array plus the address legality rule.
  logic [31:0] m2 [DEPTH];
  logic [31:0] m1 [DEPTH];
  int checks = 0;
  int errors = 0;

  function automatic bit is_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction on the LATENCY=2 instance, starting from idle.
  task automatic txn2(input bit rw, input logic [31:0] a, input logic [31:0] d,
                      input int hold);
    logic [31:0] er;
    bit          ee;
    int          n;
    ee = is_err(a);
    er = 32'd0;
    if (!ee) begin
      if (rw) m2[a[7:2]] = d;
      else    er = m2[a[7:2]];
    end
    chk("idle_req_ready", 32'(r2_ready), 32'd1);
    r2_valid = 1; r2_addr = a; r2_rw = rw; r2_wdata = d;
    @(negedge clk);
    // Request inputs are don't-care now; keep req_valid high with junk, and
    // wiggle resp_ready while not yet in RESP.
    r2_addr = $urandom; r2_rw = 1'($urandom); r2_wdata = $urandom;
    p2_ready = 1'($urandom);
    n = 1;
    while (!p2_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    p2_ready = 0;
    chk("latency", 32'(n), 32'(LAT2));
    chk("rdata", p2_rdata, er);
    chk("err", 32'(p2_err), 32'(ee));
    chk("busy_req_ready", 32'(r2_ready), 32'd0);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", 32'(p2_valid), 32'd1);
      chk("hold_rdata", p2_rdata, er);
      chk("hold_err", 32'(p2_err), 32'(ee));
      chk("hold_req_ready", 32'(r2_ready), 32'd0);
    end
    p2_ready = 1;
    @(negedge clk);
    r2_valid = 0;
    p2_ready = 0;
    chk("done_valid", 32'(p2_valid), 32'd0);
    chk("done_rdata", p2_rdata, 32'd0);
    chk("done_err", 32'(p2_err), 32'd0);
    chk("done_req_ready", 32'(r2_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] a, d, e;
    bit          rw;
    for (int i = 0; i < DEPTH; i++) begin
      m2[i] = 32'd0;
      m1[i] = 32'd0;
    end

    // Reset state
    rst = 1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(r2_ready), 32'd1);
    chk("rst_valid", 32'(p2_valid), 32'd0);
    chk("rst_rdata", p2_rdata, 32'd0);
    chk("rst_err", 32'(p2_err), 32'd0);
    rst = 0;
    @(negedge clk);

    // Directed cases
    txn2(1, 32'h10, 32'hDEADBEEF, 0);
    txn2(0, 32'h10, 32'h0, 0);
    txn2(0, 32'h13, 32'h0, 1);
    txn2(1, 32'h100, 32'h1234, 0);
    txn2(0, 32'h0, 32'h0, 0);
    txn2(1, 32'h4, 32'h5A5A_0001, 5);
    txn2(0, 32'h4, 32'h0, 5);

    // Reset one cycle after accept: request dropped, no write
    chk("pre_rst_req_ready", 32'(r2_ready), 32'd1);
    r2_valid = 1; r2_addr = 32'h20; r2_rw = 1; r2_wdata = 32'hAAAA5555;
    @(negedge clk);
    r2_valid = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("wrst_req_ready", 32'(r2_ready), 32'd1);
    repeat (3) begin
      chk("wrst_no_resp", 32'(p2_valid), 32'd0);
      @(negedge clk);
    end
    txn2(0, 32'h20, 32'h0, 0);

    // Randomized traffic
    for (int k = 0; k < 40; k++) begin
      a = 32'($urandom_range(0, 70)) * 4;
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) a = $urandom | 32'h100;
      txn2(1'($urandom), a, $urandom, $urandom_range(0, 3));
    end

    // LATENCY=1 sweep: write then read each word, next request held waiting
    for (int k = 0; k < 2 * DEPTH; k++) begin
      a  = 32'(k / 2) * 4;
      rw = (k % 2 == 0);
      d  = $urandom;
      e  = 32'd0;
      if (rw) m1[k / 2] = d;
      else    e = m1[k / 2];
      chk("l1_req_ready", 32'(r1_ready), 32'd1);
      r1_valid = 1; r1_addr = a; r1_rw = rw; r1_wdata = d;
      @(negedge clk);
      chk("l1_valid", 32'(p1_valid), 32'd1);
      chk("l1_rdata", p1_rdata, e);
      chk("l1_err", 32'(p1_err), 32'd0);
      // Junk request stays asserted across the completion edge.
      r1_addr = $urandom; r1_rw = 1'($urandom); r1_wdata = $urandom;
      @(negedge clk);
      chk("l1_done_valid", 32'(p1_valid), 32'd0);
    end
    r1_valid = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
